// File: rtl/axi_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_arbiter_pkg
//   Shared definitions for the IF/MEM to AXI4 arbiter: default bus widths,
//   the doubleword offset width used for address alignment, the FSM state
//   encoding and the transaction-owner encoding.
// -----------------------------------------------------------------------------
package axi_mem_arbiter_pkg;

    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 64;

    // Byte-offset bits inside one 64-bit doubleword; cleared on the AXI address.
    localparam int DW_OFFSET_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WA   = 3'd3,
        ST_B    = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_mem_arbiter_if
//   Single-beat AXI4 subset shared by the arbiter and the memory slave.
//   One address bus (ax_addr) serves both AR and AW because only one
//   transaction is ever in flight.
//   Modports:
//     master : arbiter side  (drives addr/valids/ready-for-responses, w data)
//     slave  : memory side   (drives address/data readies, r data, responses)
// -----------------------------------------------------------------------------
interface axi_mem_arbiter_if
    import axi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) ();

    logic [ADDR_W-1:0]   ax_addr;
    logic                ar_valid;
    logic                ar_ready;
    logic                r_valid;
    logic                r_ready;
    logic [DATA_W-1:0]   r_data;
    logic                aw_valid;
    logic                aw_ready;
    logic                w_valid;
    logic                w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                b_valid;
    logic                b_ready;

    modport master (
        output ax_addr, ar_valid, r_ready, aw_valid, w_valid, w_data, w_strb, b_ready,
        input  ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid
    );

    modport slave (
        input  ax_addr, ar_valid, r_ready, aw_valid, w_valid, w_data, w_strb, b_ready,
        output ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid
    );

endinterface

// File: rtl/axi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// axi_mem_arbiter
//   Shares the core's single AXI4 master port between instruction fetch (IF,
//   read-only) and the MEM stage (loads/stores). One single-beat transaction
//   is sequenced at a time; MEM has fixed priority over IF.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     if_req_i/if_addr_i    IF read request, held until if_done_o
//     if_done_o             one-cycle pulse, IF read complete
//     mem_req_i/mem_wen_i/mem_addr_i/mem_wdata_i/mem_wstrb_i
//                           MEM request, all held stable until mem_done_o
//     mem_done_o            one-cycle pulse, MEM read or write complete
//     rsp_rdata_o           read data, valid in the done cycle only
//     axi                   AXI master side (axi_mem_arbiter_if.master)
//   Valid/ready, ax_addr, w_data and w_strb are registered; done pulses and
//   rsp_rdata are combinational from the response beat.
// -----------------------------------------------------------------------------
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_done_o,

    input  logic                mem_req_i,
    input  logic                mem_wen_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    output logic                mem_done_o,

    output logic [DATA_W-1:0]   rsp_rdata_o,

    axi_mem_arbiter_if.master   axi
);

    // Clears the byte offset so every access is doubleword aligned;
    // requesters pick their own lanes out of the 64-bit beat.
    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        ~{{(ADDR_W-DW_OFFSET_W){1'b0}}, {DW_OFFSET_W{1'b1}}};

    arb_state_e          state_q;
    arb_owner_e          owner_q;
    logic [ADDR_W-1:0]   ax_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;
    logic                ar_valid_q;
    logic                r_ready_q;
    logic                aw_valid_q;
    logic                w_valid_q;
    logic                b_ready_q;
    logic                aw_done_q;
    logic                w_done_q;

    logic                aw_done_d;
    logic                w_done_d;
    logic                rd_beat;
    logic                wr_resp;

    // Write-channel completion including a handshake happening this cycle,
    // so AW and W finishing on the same edge still leads straight to B.
    always_comb begin
        aw_done_d = aw_done_q | (aw_valid_q & axi.aw_ready);
        w_done_d  = w_done_q  | (w_valid_q  & axi.w_ready);
    end

    // Response beats that complete a transaction; suppressed under reset so
    // an abandoned transaction never reports completion.
    always_comb begin
        rd_beat = (state_q == ST_R) & axi.r_valid & ~reset;
        wr_resp = (state_q == ST_B) & axi.b_valid & ~reset;
    end

    // Transaction FSM: arbitration, request latching and AXI handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            ax_addr_q  <= {ADDR_W{1'b0}};
            w_data_q   <= {DATA_W{1'b0}};
            w_strb_q   <= {(DATA_W/8){1'b0}};
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // MEM always wins; IF can starve while MEM keeps
                    // requesting, which is fine because MEM stalls the pipe.
                    if (mem_req_i) begin
                        owner_q   <= OWN_MEM;
                        ax_addr_q <= mem_addr_i & ALIGN_MASK;
                        w_data_q  <= mem_wdata_i;
                        w_strb_q  <= mem_wstrb_i;
                        if (mem_wen_i) begin
                            state_q    <= ST_WA;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                        end else begin
                            state_q    <= ST_AR;
                            ar_valid_q <= 1'b1;
                        end
                    end else if (if_req_i) begin
                        owner_q    <= OWN_IF;
                        ax_addr_q  <= if_addr_i & ALIGN_MASK;
                        state_q    <= ST_AR;
                        ar_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_AR: begin
                    if (axi.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= ST_R;
                    end else begin
                        state_q <= ST_AR;
                    end
                end

                ST_R: begin
                    if (axi.r_valid) begin
                        r_ready_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_R;
                    end
                end

                ST_WA: begin
                    // AW and W drop independently once each has handshaken.
                    aw_done_q  <= aw_done_d;
                    w_done_q   <= w_done_d;
                    aw_valid_q <= ~aw_done_d;
                    w_valid_q  <= ~w_done_d;
                    if (aw_done_d && w_done_d) begin
                        b_ready_q <= 1'b1;
                        state_q   <= ST_B;
                    end else begin
                        state_q <= ST_WA;
                    end
                end

                ST_B: begin
                    if (axi.b_valid) begin
                        b_ready_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_B;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    b_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign if_done_o   = rd_beat & (owner_q == OWN_IF);
    assign mem_done_o  = (rd_beat & (owner_q == OWN_MEM)) | wr_resp;
    assign rsp_rdata_o = axi.r_data;

    assign axi.ax_addr  = ax_addr_q;
    assign axi.ar_valid = ar_valid_q;
    assign axi.r_ready  = r_ready_q;
    assign axi.aw_valid = aw_valid_q;
    assign axi.w_valid  = w_valid_q;
    assign axi.w_data   = w_data_q;
    assign axi.w_strb   = w_strb_q;
    assign axi.b_ready  = b_ready_q;

endmodule
